note_sequencer: RTL and testbench

Parametrised record/playback engine for the music device. It captures keyboard note events with their held durations into an internal DEPTH-entry store, then replays them in one-shot or loop mode. It sits between convert_keyboard_input and the datapath/audio path. Its note_out/octave_out/note_valid feed the frequency datapath in place of the fixed 16-note control counter.

---
 rtl/note_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_note_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// note_sequencer: record/playback engine for keyboard note events.
// Key make/break pulses record note, octave and held duration (in ticks)
// into a DEPTH-entry store. play_start replays the store one-shot, or in a
// loop while loop_en is high.
// Optional feature macro: SEQ_TRANSPOSE_EN adds a signed 2-bit transpose
// input that is applied to the octave during playback.
// Handshake: every command input is a 1-cycle pulse sampled on the rising
// clk edge. There is no back-pressure, and a command that is illegal in the
// current state is dropped. Outputs are registered.
module note_sequencer #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int DUR_W    = 8,
  parameter int TICK_DIV = 500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        note_in,
  input  logic [1:0]        octave_in,
  input  logic              rec_strobe,
  input  logic              rec_release,
  input  logic              play_start,
  input  logic              play_stop,
  input  logic              clear,
  input  logic              loop_en,
`ifdef SEQ_TRANSPOSE_EN
  input  logic [1:0]        transpose,
`endif
  output logic [3:0]        note_out,
  output logic [1:0]        octave_out,
  output logic              note_valid,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] play_idx,
  output logic              full
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_PLAY = 2'd2;

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]     PRESC_ONE  = PW'(1);
  localparam logic [DUR_W-1:0]  DUR_MAX    = '1;
  localparam logic [DUR_W-1:0]  DUR_ONE    = DUR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   DEPTH_C    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] IDX_ONE    = ADDR_W'(1);

  logic [3:0]       mem_note [DEPTH];
  logic [1:0]       mem_oct  [DEPTH];
  logic [DUR_W-1:0] mem_dur  [DEPTH];

  logic [PW-1:0]     presc;
  logic              tick;
  logic [DUR_W-1:0]  dur;
  logic [DUR_W-1:0]  remaining;
  logic [DUR_W-1:0]  close_dur;
  logic [ADDR_W:0]   count_inc;
  logic              more_entries;
  logic [ADDR_W-1:0] ld_idx;
  logic [3:0]        ld_note;
  logic [1:0]        ld_oct;
  logic [DUR_W-1:0]  ld_dur;
  logic              do_open;
  logic              do_close;
  logic [ADDR_W-1:0] open_addr;

  assign tick         = (state != ST_IDLE) && (presc == PRESC_LAST);
  assign count_inc    = count + CNT_ONE;
  assign full         = (count == DEPTH_C);
  // A zero-length entry would never sound, so the shortest stored duration is one tick.
  assign close_dur    = (dur == '0) ? DUR_ONE : dur;
  assign more_entries = (((ADDR_W+1)'(play_idx)) + CNT_ONE) < count;
  // Entry 0 on play_start and on wrap; otherwise the next entry.
  assign ld_idx       = (state == ST_PLAY && more_entries) ? play_idx + IDX_ONE : '0;
  assign ld_note      = mem_note[ld_idx];
  assign ld_dur       = mem_dur[ld_idx];

`ifdef SEQ_TRANSPOSE_EN
  // Octave of the entry being loaded, shifted by transpose and clamped to 0..3.
  always_comb begin
    int sum;
    sum = int'(mem_oct[ld_idx]) + int'($signed(transpose));
    if (sum < 0)      ld_oct = 2'd0;
    else if (sum > 3) ld_oct = 2'd3;
    else              ld_oct = 2'(sum);
  end
`else
  assign ld_oct = mem_oct[ld_idx];
`endif

  // Decide when an entry is opened (note/octave written) or closed (duration written).
  always_comb begin
    do_open   = 1'b0;
    do_close  = 1'b0;
    open_addr = count[ADDR_W-1:0];
    case (state)
      ST_IDLE: begin
        if (!clear && !(play_start && count != '0) && rec_strobe && !full)
          do_open = 1'b1;
      end
      ST_HOLD: begin
        if (!play_stop) begin
          if (rec_release) begin
            do_close = 1'b1;
          end else if (rec_strobe) begin
            do_close = 1'b1;
            if (count_inc < DEPTH_C) begin
              do_open   = 1'b1;
              open_addr = count_inc[ADDR_W-1:0];
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Entry storage: synchronous writes, no reset needed.
  always_ff @(posedge clk) begin
    if (do_open) begin
      mem_note[open_addr] <= note_in;
      mem_oct[open_addr]  <= octave_in;
    end
    if (do_close)
      mem_dur[count[ADDR_W-1:0]] <= close_dur;
  end

  // Control FSM, tick prescaler, duration counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      play_idx   <= '0;
      note_out   <= '0;
      octave_out <= '0;
      note_valid <= 1'b0;
      presc      <= '0;
      dur        <= '0;
      remaining  <= '0;
    end else begin
      if (state == ST_IDLE || tick) presc <= '0;
      else                          presc <= presc + PRESC_ONE;
      case (state)
        ST_IDLE: begin
          if (clear) begin
            count <= '0;
          end else if (play_start && count != '0) begin
            state      <= ST_PLAY;
            play_idx   <= '0;
            presc      <= '0;
            note_out   <= ld_note;
            octave_out <= ld_oct;
            remaining  <= ld_dur;
            note_valid <= 1'b1;
          end else if (do_open) begin
            state      <= ST_HOLD;
            dur        <= '0;
            presc      <= '0;
            note_out   <= note_in;
            octave_out <= octave_in;
            note_valid <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (tick && dur != DUR_MAX) dur <= dur + DUR_ONE;
          if (play_stop) begin
            state      <= ST_IDLE;
            note_out   <= '0;
            octave_out <= '0;
            note_valid <= 1'b0;
          end else if (do_close) begin
            count <= count_inc;
            if (do_open) begin
              dur        <= '0;
              presc      <= '0;
              note_out   <= note_in;
              octave_out <= octave_in;
            end else begin
              state      <= ST_IDLE;
              note_out   <= '0;
              octave_out <= '0;
              note_valid <= 1'b0;
            end
          end
        end
        ST_PLAY: begin
          if (play_stop) begin
            state      <= ST_IDLE;
            note_out   <= '0;
            octave_out <= '0;
            note_valid <= 1'b0;
          end else if (tick) begin
            if (remaining > DUR_ONE) begin
              remaining <= remaining - DUR_ONE;
            end else if (more_entries || loop_en) begin
              play_idx   <= ld_idx;
              note_out   <= ld_note;
              octave_out <= ld_oct;
              remaining  <= ld_dur;
            end else begin
              state      <= ST_IDLE;
              note_out   <= '0;
              octave_out <= '0;
              note_valid <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Testbench for note_sequencer: directed record/playback steps with a queue
// of expected playback entries {idx, note, octave, dur}.
module tb_note_sequencer;

  localparam int DEPTH    = 4;
  localparam int ADDR_W   = 2;
  localparam int DUR_W    = 8;
  localparam int TICK_DIV = 4;
  localparam int EW       = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        note_in = '0;
  logic [1:0]        octave_in = '0;
  logic              rec_strobe = 1'b0;
  logic              rec_release = 1'b0;
  logic              play_start = 1'b0;
  logic              play_stop = 1'b0;
  logic              clear = 1'b0;
  logic              loop_en = 1'b0;
  logic [3:0]        note_out;
  logic [1:0]        octave_out;
  logic              note_valid;
  logic [1:0]        state;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] play_idx;
  logic              full;

  logic [EW-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  // Clock and reset
  always #5 clk = ~clk;

  note_sequencer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk), .reset(rst_n), .note_in(note_in), .octave_in(octave_in),
    .rec_strobe(rec_strobe), .rec_release(rec_release), .play_start(play_start),
    .play_stop(play_stop), .clear(clear), .loop_en(loop_en),
    .note_out(note_out), .octave_out(octave_out), .note_valid(note_valid),
    .state(state), .count(count), .play_idx(play_idx), .full(full)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Duration stored for a release h edges after the strobe edge.
  function automatic logic [7:0] exp_dur(input int h);
    int d;
    d = (h - 1) / TICK_DIV;
    if (d < 1) d = 1;
    if (d > 255) d = 255;
    return 8'(d);
  endfunction

  task automatic push(input logic [1:0] idx, input logic [3:0] n, input logic [1:0] o,
                      input logic [7:0] d);
    exp_q.push_back({idx, n, o, d});
  endtask

  task automatic pulse_start();
    play_start = 1'b1; step(); play_start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  // Record one note held for h edges; room=0 means the strobe must be dropped.
  task automatic rec(input logic [3:0] n, input logic [1:0] o, input int h, input bit room);
    note_in = n; octave_in = o;
    rec_strobe = 1'b1; step(); rec_strobe = 1'b0;
    if (room) begin
      chk("hold_state", 32'(state), 32'd1);
      chk("hold_note", 32'(note_out), 32'(n));
      chk("hold_oct", 32'(octave_out), 32'(o));
    end else begin
      chk("full_ignore_state", 32'(state), 32'd0);
    end
    repeat (h - 1) step();
    rec_release = 1'b1; step(); rec_release = 1'b0;
    chk("rec_idle", 32'(state), 32'd0);
  endtask

  // Pop one expected entry and measure how long the DUT sounds it.
  task automatic play_entry(input string tag);
    logic [EW-1:0] e;
    logic [ADDR_W-1:0] idx;
    int cyc;
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $error("FAIL %s_queue: got empty expected entry", tag);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_idx"}, 32'(play_idx), 32'(e[15:14]));
    chk({tag, "_note"}, 32'(note_out), 32'(e[13:10]));
    chk({tag, "_oct"}, 32'(octave_out), 32'(e[9:8]));
    chk({tag, "_valid"}, 32'(note_valid), 32'd1);
    idx = play_idx;
    cyc = 0;
    while (note_valid && play_idx == idx && state == 2'd2 && cyc < 3000) begin
      cyc++;
      step();
    end
    chk({tag, "_len"}, 32'(cyc), 32'(e[7:0]) * TICK_DIV);
  endtask

  initial begin
    // Reset
    repeat (2) step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_idx", 32'(play_idx), 32'd0);
    chk("rst_note", 32'(note_out), 32'd0);
    chk("rst_valid", 32'(note_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    rst_n = 1'b1;
    step();

    // Single note held 13 cycles -> dur 3, plays 12 cycles
    rec(4'd5, 2'd2, 13, 1'b1);
    chk("t1_count", 32'(count), 32'd1);
    push(2'd0, 4'd5, 2'd2, exp_dur(13));
    pulse_start();
    play_entry("t1");
    chk("t1_end_state", 32'(state), 32'd0);
    chk("t1_end_valid", 32'(note_valid), 32'd0);
    chk("t1_end_note", 32'(note_out), 32'd0);

    // Very short hold stores dur 1
    pulse_clear();
    rec(4'd9, 2'd1, 2, 1'b1);
    push(2'd0, 4'd9, 2'd1, exp_dur(2));
    pulse_start();
    play_entry("t2");
    chk("t2_end_state", 32'(state), 32'd0);

    // Fill the store, fifth record dropped, clear, play_start ignored
    pulse_clear();
    for (int i = 0; i < DEPTH; i++) rec(4'($urandom_range(0, 15)), 2'(i), 5, 1'b1);
    rec(4'd3, 2'd3, 5, 1'b0);
    chk("t3_count", 32'(count), 32'(DEPTH));
    chk("t3_full", 32'(full), 32'd1);
    pulse_clear();
    chk("t3_clr_count", 32'(count), 32'd0);
    chk("t3_clr_full", 32'(full), 32'd0);
    pulse_start();
    chk("t3_nostart_state", 32'(state), 32'd0);
    chk("t3_nostart_valid", 32'(note_valid), 32'd0);

    // Three entries looped: 0,1,2,0,1 then stop mid-entry
    rec(4'd1, 2'd0, 5, 1'b1);
    rec(4'd2, 2'd1, 9, 1'b1);
    rec(4'd3, 2'd3, 5, 1'b1);
    chk("t4_count", 32'(count), 32'd3);
    push(2'd0, 4'd1, 2'd0, exp_dur(5));
    push(2'd1, 4'd2, 2'd1, exp_dur(9));
    push(2'd2, 4'd3, 2'd3, exp_dur(5));
    push(2'd0, 4'd1, 2'd0, exp_dur(5));
    push(2'd1, 4'd2, 2'd1, exp_dur(9));
    loop_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 5; i++) play_entry($sformatf("t4_%0d", i));
    chk("t4_third_idx", 32'(play_idx), 32'd2);
    step();
    play_stop = 1'b1; step(); play_stop = 1'b0;
    chk("t4_stop_state", 32'(state), 32'd0);
    chk("t4_stop_valid", 32'(note_valid), 32'd0);
    chk("t4_stop_note", 32'(note_out), 32'd0);
    loop_en = 1'b0;

    // play_stop together with clear in IDLE still clears
    pulse_clear();
    rec(4'd6, 2'd1, 5, 1'b1);
    rec(4'd8, 2'd2, 5, 1'b1);
    chk("t5_count", 32'(count), 32'd2);
    play_stop = 1'b1; clear = 1'b1; step(); play_stop = 1'b0; clear = 1'b0;
    chk("t5_clr_count", 32'(count), 32'd0);

    // rec_strobe in HOLD closes the entry and opens the next one
    note_in = 4'd4; octave_in = 2'd0;
    rec_strobe = 1'b1; step(); rec_strobe = 1'b0;
    repeat (5) step();
    note_in = 4'd7; octave_in = 2'd3;
    rec_strobe = 1'b1; step(); rec_strobe = 1'b0;
    chk("t6_count", 32'(count), 32'd1);
    chk("t6_state", 32'(state), 32'd1);
    chk("t6_note", 32'(note_out), 32'd7);
    chk("t6_oct", 32'(octave_out), 32'd3);
    repeat (8) step();
    rec_release = 1'b1; step(); rec_release = 1'b0;
    chk("t6_count2", 32'(count), 32'd2);
    push(2'd0, 4'd4, 2'd0, exp_dur(6));
    push(2'd1, 4'd7, 2'd3, exp_dur(9));
    pulse_start();
    play_entry("t6_a");
    play_entry("t6_b");
    chk("t6_end_state", 32'(state), 32'd0);

    // Asynchronous reset in the middle of playback
    pulse_start();
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("t7_async_note", 32'(note_out), 32'd0);
    chk("t7_async_valid", 32'(note_valid), 32'd0);
    chk("t7_async_state", 32'(state), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("t7_count", 32'(count), 32'd0);
    chk("t7_idx", 32'(play_idx), 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
